mdu_controller: RTL and testbench

Multi-cycle multiply/divide sequencer for the pipelined MIPS core. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage, runs an iterative 32-step shift-add or restoring-divide datapath, and owns the HI/LO registers. It raises a stall request to the hazard logic only when a later instruction needs HI/LO while an operation is in flight.

---
 rtl/mdu_controller.sv | 190 +++++++++++++++++++
 tb/tb_mdu_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_controller.sv
// Iterative 32-bit multiply/divide sequencer that owns the HI/LO registers.
// Optional MDU_FAST_MUL_EN: single-cycle multiplier for MULT/MULTU; divides stay iterative.
module mdu_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mduOpE,
  input  logic        mduStartE,
  input  logic [31:0] srcAE,
  input  logic [31:0] srcBE,
  input  logic        hiloUseD,
  input  logic        flushE,
  output logic [31:0] hiOut,
  output logic [31:0] loOut,
  output logic        mduBusy,
  output logic        mduStall,
  output logic        mduDone
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   opa_q, opa_d;   // multiplicand or divisor
  logic [XLEN-1:0]   opb_q, opb_d;   // multiplier, shifted left each step
  logic [2*XLEN-1:0] acc_q, acc_d;   // product, or {remainder, dividend/quotient}
  logic              is_div_q, is_div_d;
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              is_signed_c, is_mul_c, is_div_c, accept_c;
  logic [XLEN-1:0]   abs_a_c, abs_b_c;
  logic [2*XLEN-1:0] mul_next_c, fast_prod_c, fast_res_c, prod_fix_c;
  logic [XLEN:0]     div_trial_c, div_rem_c;
  logic              div_ge_c;
  logic [2*XLEN-1:0] div_next_c;

  // Operand decode and sign handling for the issuing instruction
  always_comb begin
    is_signed_c = (mduOpE == OP_MULT) || (mduOpE == OP_DIV);
    is_mul_c    = (mduOpE == OP_MULT) || (mduOpE == OP_MULTU);
    is_div_c    = (mduOpE == OP_DIV)  || (mduOpE == OP_DIVU);
    accept_c    = mduStartE && !flushE && (state_q == S_IDLE);
    abs_a_c     = (is_signed_c && srcAE[XLEN-1]) ? -srcAE : srcAE;
    abs_b_c     = (is_signed_c && srcBE[XLEN-1]) ? -srcBE : srcBE;
    fast_prod_c = (2*XLEN)'(abs_a_c) * (2*XLEN)'(abs_b_c);
    fast_res_c  = (is_signed_c && (srcAE[XLEN-1] ^ srcBE[XLEN-1])) ? -fast_prod_c : fast_prod_c;
  end

  // One shift-add or restoring-divide iteration
  always_comb begin
    mul_next_c  = {acc_q[2*XLEN-2:0], 1'b0} +
                  (opb_q[XLEN-1] ? (2*XLEN)'(opa_q) : (2*XLEN)'(0));
    div_trial_c = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge_c    = div_trial_c >= {1'b0, opa_q};
    div_rem_c   = div_ge_c ? (div_trial_c - {1'b0, opa_q}) : div_trial_c;
    div_next_c  = {div_rem_c[XLEN-1:0], acc_q[XLEN-2:0], div_ge_c};
    prod_fix_c  = neg_q_q ? -acc_q : acc_q;
  end

  // Next-state and register updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (is_div_c || (is_mul_c && !FAST_MUL)) begin
            state_d  = S_CALC;
            cnt_d    = '0;
            is_div_d = is_div_c;
            neg_q_d  = is_signed_c && (srcAE[XLEN-1] ^ srcBE[XLEN-1]);
            neg_r_d  = is_signed_c && srcAE[XLEN-1];
            if (is_div_c) begin
              opa_d = abs_b_c;
              opb_d = '0;
              acc_d = (2*XLEN)'(abs_a_c);
            end else begin
              opa_d = abs_a_c;
              opb_d = abs_b_c;
              acc_d = '0;
            end
          end else if (is_mul_c) begin
            hi_d   = fast_res_c[2*XLEN-1:XLEN];
            lo_d   = fast_res_c[XLEN-1:0];
            done_d = 1'b1;
          end else if (mduOpE == OP_MTHI) begin
            hi_d = srcAE;
          end else if (mduOpE == OP_MTLO) begin
            lo_d = srcAE;
          end
        end
      end
      S_CALC: begin
        if (flushE) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          acc_d = is_div_q ? div_next_c : mul_next_c;
          opb_d = {opb_q[XLEN-2:0], 1'b0};
          if (cnt_q == LAST_CNT) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flushE) begin
          done_d = 1'b1;
          if (is_div_q) begin
            lo_d = neg_q_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
            hi_d = neg_r_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
          end else begin
            hi_d = prod_fix_c[2*XLEN-1:XLEN];
            lo_d = prod_fix_c[XLEN-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign hiOut    = hi_q;
  assign loOut    = lo_q;
  assign mduBusy  = busy_q;
  assign mduDone  = done_q;
  assign mduStall = busy_q & hiloUseD;

endmodule

// File: tb/tb_mdu_controller.sv
// Self-checking bench for mdu_controller: behavioural HI/LO model, directed cases and random traffic.
module tb_mdu_controller;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  mduOpE = OP_NONE;
  logic        mduStartE = 1'b0;
  logic [31:0] srcAE = '0;
  logic [31:0] srcBE = '0;
  logic        hiloUseD = 1'b0;
  logic        flushE = 1'b0;
  logic [31:0] hiOut, loOut;
  logic        mduBusy, mduStall, mduDone;

  int vectors = 0;
  int miscompares = 0;
  int stall_cnt = 0;
  int done_cnt = 0;

  // Model: HI/LO contents, pending result, busy cycles left
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;
  int          m_rem = 0;
  bit          m_done = 1'b0;

  mdu_controller dut (
    .clk(clk), .rst(rst_n), .mduOpE(mduOpE), .mduStartE(mduStartE),
    .srcAE(srcAE), .srcBE(srcBE), .hiloUseD(hiloUseD), .flushE(flushE),
    .hiOut(hiOut), .loOut(loOut), .mduBusy(mduBusy), .mduStall(mduStall),
    .mduDone(mduDone)
  );

  always #5 clk = ~clk;

  // Returns {HI, LO} for a multiply or divide
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sp;
    logic [31:0] ua, ub, q, r;
    bit sgn;
    if (op == OP_MULT) begin
      sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      return sp;
    end else if (op == OP_MULTU) begin
      return {32'b0, a} * {32'b0, b};
    end
    sgn = (op == OP_DIV);
    ua = (sgn && a[31]) ? -a : a;
    ub = (sgn && b[31]) ? -b : b;
    if (ub == 0) begin
      q = 32'hFFFFFFFF;
      r = ua;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if (sgn && (a[31] ^ b[31])) q = -q;
    if (sgn && a[31]) r = -r;
    return {r, q};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_rem = 0; m_done = 1'b0; m_pend = '0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        if (flushE) m_rem = 0;
        else if (m_rem == 1) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1'b1;
          m_rem = 0;
        end else m_rem = m_rem - 1;
      end else if (mduStartE && !flushE) begin
        case (mduOpE)
          OP_MULT, OP_MULTU: begin
            if (FAST) begin
              {m_hi, m_lo} = ref_result(mduOpE, srcAE, srcBE);
              m_done = 1'b1;
            end else begin
              m_pend = ref_result(mduOpE, srcAE, srcBE);
              m_rem = 33;
            end
          end
          OP_DIV, OP_DIVU: begin
            m_pend = ref_result(mduOpE, srcAE, srcBE);
            m_rem = 33;
          end
          OP_MTHI: m_hi = srcAE;
          OP_MTLO: m_lo = srcAE;
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one clock and compare every output with the model
  task automatic tick();
    @(posedge clk);
    #2;
    chk("busy", 64'(mduBusy), 64'(m_rem > 0));
    chk("done", 64'(mduDone), 64'(m_done));
    chk("hi", 64'(hiOut), 64'(m_hi));
    chk("lo", 64'(loOut), 64'(m_lo));
    chk("stall", 64'(mduStall), 64'((m_rem > 0) && hiloUseD));
    if (mduStall) stall_cnt++;
    if (mduDone) done_cnt++;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mduOpE = op; srcAE = a; srcBE = b; mduStartE = 1'b1;
    tick();
    mduStartE = 1'b0; mduOpE = OP_NONE;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && m_rem > 0; i++) tick();
    if (m_rem > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: still busy after 40 cycles at %0t", $time);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #12;
    chk("rst_hi", 64'(hiOut), 64'h0);
    chk("rst_lo", 64'(loOut), 64'h0);
    chk("rst_busy", 64'(mduBusy), 64'h0);
    chk("rst_done", 64'(mduDone), 64'h0);
    rst_n = 1'b1;
    tick();

    done_cnt = 0;
    issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
    wait_idle();
    chk("mult_hi", 64'(hiOut), 64'hFFFFFFFF);
    chk("mult_lo", 64'(loOut), 64'hFFFFFFF1);
    chk("mult_done_pulses", 64'(done_cnt), 64'd1);

    issue(OP_DIVU, 32'd100, 32'd7);
    wait_idle();
    chk("divu_lo", 64'(loOut), 64'd14);
    chk("divu_hi", 64'(hiOut), 64'd2);

    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle();
    chk("div_lo", 64'(loOut), 64'hFFFFFFFD);
    chk("div_hi", 64'(hiOut), 64'hFFFFFFFF);

    issue(OP_DIVU, 32'd123, 32'd0);
    wait_idle();
    chk("dz_lo", 64'(loOut), 64'hFFFFFFFF);
    chk("dz_hi", 64'(hiOut), 64'd123);
    chk("dz_busy", 64'(mduBusy), 64'h0);

    hiloUseD = 1'b1;
    stall_cnt = 0;
    issue(OP_DIV, 32'd50, 32'd3);
    wait_idle();
    chk("stall_cycles", 64'(stall_cnt), 64'd33);
    tick();
    chk("stall_after", 64'(mduStall), 64'h0);
    hiloUseD = 1'b0;
    stall_cnt = 0;
    issue(OP_DIV, 32'd50, 32'd3);
    wait_idle();
    chk("nostall_cycles", 64'(stall_cnt), 64'd0);

    issue(OP_MTHI, 32'hDEADBEEF, 32'h0);
    done_cnt = 0;
    issue(OP_MULTU, 32'h10000, 32'h10000);
    for (int i = 0; i < 9; i++) tick();
    flushE = 1'b1;
    tick();
    flushE = 1'b0;
    chk("flush_busy", 64'(mduBusy), 64'h0);
    chk("flush_hi", 64'(hiOut), FAST ? 64'h1 : 64'hDEADBEEF);
    tick();
    chk("flush_done_pulses", 64'(done_cnt), FAST ? 64'd1 : 64'd0);

    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle();
    chk("multu_max_hi", 64'(hiOut), 64'hFFFFFFFE);
    chk("multu_max_lo", 64'(loOut), 64'h1);

    issue(OP_DIV, 32'd1000, 32'd7);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_hi", 64'(hiOut), 64'h0);
    chk("arst_lo", 64'(loOut), 64'h0);
    chk("arst_busy", 64'(mduBusy), 64'h0);
    #1;
    rst_n = 1'b1;
    tick();

    for (int n = 0; n < 4000; n++) begin
      hiloUseD = 1'($urandom_range(0, 1));
      flushE = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) begin
        mduStartE = 1'b1;
        mduOpE = 3'($urandom_range(0, 7));
        srcAE = pick();
        srcBE = pick();
      end else begin
        mduStartE = 1'b0;
        mduOpE = OP_NONE;
      end
      tick();
    end
    mduStartE = 1'b0;
    flushE = 1'b0;
    wait_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
